// File: rtl/counter_arbiter_if.sv
// Requester command bus and external counter control/status for counter_arbiter.
// rco_count exists only when COUNTER_ARBITER_RCO_STATS_EN is defined.
interface counter_arbiter_if;
  logic [1:0] req_valid;
  logic [3:0] req_mode;
  logic [7:0] req_data;
  logic [7:0] req_len;
  logic [1:0] req_ready;
  logic       cnt_enable;
  logic [1:0] cnt_mode;
  logic [3:0] cnt_D;
  logic [3:0] cnt_Q;
  logic       cnt_rco;
  logic [1:0] done;
  logic [3:0] result;
  logic       result_ovf;
  logic       busy;
  logic       owner;
`ifdef COUNTER_ARBITER_RCO_STATS_EN
  logic [7:0] rco_count;
`endif

  modport slave (
    input  req_valid, req_mode, req_data, req_len, cnt_Q, cnt_rco,
    output `ifdef COUNTER_ARBITER_RCO_STATS_EN rco_count, `endif
           req_ready, cnt_enable, cnt_mode, cnt_D, done, result, result_ovf, busy, owner
  );

  modport master (
    output req_valid, req_mode, req_data, req_len, cnt_Q, cnt_rco,
    input  `ifdef COUNTER_ARBITER_RCO_STATS_EN rco_count, `endif
           req_ready, cnt_enable, cnt_mode, cnt_D, done, result, result_ovf, busy, owner
  );
endinterface

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that runs jobs on an external 4-bit counter.
// Optional COUNTER_ARBITER_RCO_STATS_EN adds a saturating count of RUN cycles with cnt_rco high.
module counter_arbiter (
  input  logic              clk,
  input  logic              reset_L,
  counter_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_mode;
  logic [3:0] r_data, r_len, r_remain, r_result;
  logic       r_owner, r_prio, r_ovf, r_result_ovf;
  logic       w_grant_vld, w_grant_idx, w_take;

  // Tie goes to r_prio; a single valid requester always wins.
  assign w_grant_vld = |bus.req_valid;
  assign w_grant_idx = (&bus.req_valid) ? r_prio : bus.req_valid[1];
  assign w_take      = (r_state == S_IDLE) && w_grant_vld;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant_vld) w_next = S_LOAD;
      S_LOAD: w_next = (r_mode == 2'b11 || r_len == 4'd0) ? S_DONE : S_RUN;
      S_RUN:  if (r_remain == 4'd1) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 2'b00;
    bus.cnt_enable = 1'b0;
    bus.cnt_mode   = 2'b00;
    bus.cnt_D      = 4'b0000;
    bus.done       = 2'b00;
    bus.busy       = (r_state != S_IDLE);
    case (r_state)
      // Gated by reset_L so the combinational grant stays quiet while reset is held.
      S_IDLE: if (w_grant_vld && reset_L) bus.req_ready = w_grant_idx ? 2'b10 : 2'b01;
      S_LOAD: begin
        bus.cnt_enable = 1'b1;
        bus.cnt_mode   = 2'b11;
        bus.cnt_D      = r_data;
      end
      S_RUN: begin
        bus.cnt_enable = 1'b1;
        bus.cnt_mode   = r_mode;
        bus.cnt_D      = r_data;
      end
      S_DONE: begin
        bus.cnt_enable = 1'b1;
        bus.cnt_mode   = r_mode;
        bus.cnt_D      = r_data;
        bus.done       = r_owner ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_mode       <= 2'b00;
      r_data       <= 4'b0000;
      r_len        <= 4'b0000;
      r_remain     <= 4'b0000;
      r_owner      <= 1'b0;
      r_prio       <= 1'b0;
      r_ovf        <= 1'b0;
      r_result     <= 4'b0000;
      r_result_ovf <= 1'b0;
    end else begin
      if (w_take) begin
        r_mode  <= bus.req_mode[{w_grant_idx, 1'b0} +: 2];
        r_data  <= bus.req_data[{w_grant_idx, 2'b00} +: 4];
        r_len   <= bus.req_len[{w_grant_idx, 2'b00} +: 4];
        r_owner <= w_grant_idx;
        r_ovf   <= 1'b0;
      end
      if (r_state == S_LOAD) r_remain <= r_len;
      if (r_state == S_RUN) begin
        r_remain <= r_remain - 4'd1;
        if (bus.cnt_rco) r_ovf <= 1'b1;
      end
      if (r_state == S_DONE) begin
        r_result     <= bus.cnt_Q;
        r_result_ovf <= r_ovf;
        r_prio       <= ~r_owner;
      end
    end
  end

  assign bus.result     = r_result;
  assign bus.result_ovf = r_result_ovf;
  assign bus.owner      = r_owner;

`ifdef COUNTER_ARBITER_RCO_STATS_EN
  logic [7:0] r_rco_count;
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_rco_count <= 8'd0;
    else if (r_state == S_RUN && bus.cnt_rco && r_rco_count != 8'd255)
      r_rco_count <= r_rco_count + 8'd1;
  end
  assign bus.rco_count = r_rco_count;
`endif
endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on rising edge.
  reset_L  in  1  asynchronous, active-low reset.
  req_valid  in  2  bit i: requester i offers a command.
  req_mode  in  4  [2i+1:2i]: counter mode for requester i (00 +3, 01 -1, 10 +1, 11 load).
  req_data  in  8  [4i+3:4i]: preload value for requester i.
  req_len  in  8  [4i+3:4i]: run length in cycles for requester i.
  req_ready  out  2  bit i: command of requester i accepted this cycle.
  cnt_enable  out  1  counter enable.
  cnt_mode  out  2  counter mode select.
  cnt_D  out  4  counter parallel-load data.
  cnt_Q  in  4  counter value.
  cnt_rco  in  1  counter ripple-carry out.
  done  out  2  bit i: one-cycle pulse, requester i's job finished.
  result  out  4  final counter value of the last job.
  result_ovf  out  1  cnt_rco seen high during the last job.
  busy  out  1  high in every state except IDLE.
  owner  out  1  index of the current or last granted requester.

Function
REQ-002 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-003 SHALL keep cnt_enable=0, cnt_mode=00 and cnt_D=0000 in IDLE.
REQ-004 In IDLE with any req_valid high, SHALL grant one requester:
  - assert req_ready for that requester only, for exactly one cycle;
  - latch its mode, data and len;
  - set owner to its index and go to LOAD.
REQ-005 SHALL break a tie (both valid) round-robin: the requester not granted most recently wins.
REQ-006 SHALL drive in LOAD, for exactly one cycle: cnt_enable=1, cnt_mode=11, cnt_D=latched data.
REQ-007 SHALL leave LOAD for DONE if the latched mode is 11 or the latched len is 0; otherwise for RUN with remaining=len.
REQ-008 SHALL drive in RUN: cnt_enable=1, cnt_mode=latched mode, cnt_D=latched data; remaining decrements each cycle.
REQ-009 SHALL go from RUN to DONE after the cycle in which remaining equals 1, giving exactly len RUN cycles.
REQ-010 SHALL set a sticky overflow flag when cnt_rco=1 in any RUN cycle; the flag clears on each new grant.
REQ-011 In DONE (one cycle), SHALL:
  - drive cnt_enable=1, cnt_mode=latched mode, cnt_D=latched data, so the counter is not tristated;
  - register result<=cnt_Q and result_ovf<=flag;
  - pulse done[owner]; then return to IDLE.
  NOTE: the counter value advances once more on this edge; result reflects cnt_Q sampled before that edge.
REQ-012 SHALL ignore req_valid outside IDLE; req_ready stays 00; no new grant in the DONE cycle.
REQ-013 SHALL update the round-robin pointer in DONE.
REQ-014 SHALL hold result and result_ovf until the next DONE.
REQ-015 SHALL have job latency, grant to done pulse, of 2+len cycles (2 cycles when len=0 or mode=11).

Reset
REQ-016 SHALL, while reset_L=0, force asynchronously:
  - state=IDLE; req_ready, done, cnt_enable, busy, owner, result_ovf = 0;
  - cnt_mode=00, cnt_D=0000, result=0000;
  - round-robin pointer favouring requester 0.
REQ-017 SHALL abort a job on reset asserted mid-job, with no done pulse.

Configuration
REQ-018 With macro COUNTER_ARBITER_RCO_STATS_EN defined, SHALL add output rco_count (8 bits):
  - increments in every RUN cycle with cnt_rco=1;
  - saturates at 255;
  - cleared only by reset.
REQ-019 Without COUNTER_ARBITER_RCO_STATS_EN, SHALL have neither the rco_count port nor its logic; all other behaviour is identical.

Verification
REQ-020 Single job, req 0, mode 10, data 0011, len 4 -> ready[0] 1 cycle; LOAD with cnt_D=0011; 4 RUN cycles mode 10; done[0] 6 cycles after grant; result=0111.
REQ-021 Both valid after reset -> req 0 granted first. Both held valid -> req 1 granted next job, then req 0 again.
REQ-022 Mode 11, data 1010 -> LOAD then DONE; no RUN; result=1010; latency 2.
REQ-023 Mode 00, data 1100, len 2; model drives cnt_rco=1 in the first RUN cycle -> result_ovf=1; with the macro, rco_count=1.
REQ-024 reset_L low during RUN -> outputs at reset values immediately; no done pulse; next job after release grants req 0 on a tie.
